// File: rtl/mem_arbiter.sv
// Port-1 round-robin arbiter (loader vs data) plus dedicated fetch port for a dual-port memory.
// Read data is steered back to its requester one cycle after the grant.
module mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ldr_mode,
    input  logic                 ldr_req,
    input  logic [ADDR_SIZE-1:0] ldr_addr,
    input  logic [WORD_SIZE-1:0] ldr_wdata,
    output logic                 ldr_gnt,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [WORD_SIZE-1:0] d_rdata,
    input  logic                 f_req,
    input  logic [ADDR_SIZE-1:0] f_addr,
    output logic                 f_gnt,
    output logic                 f_rvalid,
    output logic [WORD_SIZE-1:0] f_rdata,
    output logic                 mem_r_en1,
    output logic                 mem_w_en,
    output logic                 mem_r_en2,
    output logic [ADDR_SIZE-1:0] mem_addr1,
    output logic [ADDR_SIZE-1:0] mem_addr2,
    output logic [WORD_SIZE-1:0] mem_w_data,
    input  logic [WORD_SIZE-1:0] mem_r_data1,
    input  logic [WORD_SIZE-1:0] mem_r_data2
);

    logic rr;       // 0: data preferred, 1: loader preferred
    logic d_pend;
    logic f_pend;
    logic hazard;

    always_comb begin
        d_gnt   = d_req & (~ldr_req | ~rr) & ~reset;
        ldr_gnt = ldr_req & (~d_req | rr) & ~reset;

        mem_w_en   = ldr_gnt | (d_gnt & d_we);
        mem_r_en1  = d_gnt & ~d_we;
        mem_addr1  = ldr_gnt ? ldr_addr : d_addr;
        mem_w_data = ldr_gnt ? ldr_wdata : d_wdata;

        // Holding fetch off a same-address write removes any dependence on the
        // memory's write/read ordering within a cycle.
        hazard    = mem_w_en & (mem_addr1 == f_addr);
        f_gnt     = f_req & ~ldr_mode & ~hazard & ~reset;
        mem_r_en2 = f_gnt;
        mem_addr2 = f_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr     <= 1'b0;
            d_pend <= 1'b0;
            f_pend <= 1'b0;
        end else begin
            if (d_gnt)
                rr <= 1'b1;
            else if (ldr_gnt)
                rr <= 1'b0;
            d_pend <= d_gnt & ~d_we;
            f_pend <= f_gnt;
        end
    end

    assign d_rvalid = d_pend;
    assign d_rdata  = mem_r_data1;
    assign f_rvalid = f_pend;
    assign f_rdata  = mem_r_data2;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing and arbitration front-end for the dual-port program/data memory (`mem_2port`). It shares memory port 1 (read/write) between the data load/store unit and the program loader, dedicates port 2 (read-only) to instruction fetch, and returns read data to the issuing requester one cycle after grant. It also suppresses fetch during load mode and on same-address port-1 writes, so the memory's same-cycle write/read ordering never matters.

## Interface
- WORD_SIZE, 16, data word width
- ADDR_SIZE, 16, address width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ldr_mode  in  1  loader mode: fetch is blocked while high
- ldr_req  in  1  loader write request
- ldr_addr  in  ADDR_SIZE  loader write address
- ldr_wdata  in  WORD_SIZE  loader write data
- ldr_gnt  out  1  loader request accepted this cycle
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_SIZE  data address
- d_wdata  in  WORD_SIZE  data write word
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid (read granted previous cycle)
- d_rdata  out  WORD_SIZE  data read word
- f_req  in  1  fetch read request
- f_addr  in  ADDR_SIZE  fetch address
- f_gnt  out  1  fetch accepted this cycle
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  WORD_SIZE  fetched word
- mem_r_en1, mem_w_en, mem_r_en2  out  1 each  memory strobes
- mem_addr1, mem_addr2  out  ADDR_SIZE  memory addresses
- mem_w_data  out  WORD_SIZE  memory write data
- mem_r_data1, mem_r_data2  in  WORD_SIZE  registered memory read data

## Operation
- Handshake: a transfer happens on a rising edge where req and gnt are both high. Requesters hold req, address and data stable until granted. gnt is combinational from the req inputs and arbiter state.
- Port 1 arbitration between ldr and d uses round-robin with a 1-bit pointer `rr` (0 = d preferred, 1 = ldr preferred).
  - Only one requesting: it wins.
  - Both requesting: the preferred one wins.
  - After any port-1 grant, `rr` points to the loser side, so the other requester is preferred next.
- Port 1 drive on a d-read grant: mem_r_en1=1, mem_w_en=0, mem_addr1=d_addr.
- Port 1 drive on a write grant (d_we=1 or ldr): mem_w_en=1, mem_r_en1=0, mem_addr1/mem_w_data from the winner.
- mem_r_en1 and mem_w_en are never both high.
- With no port-1 grant, both strobes are 0.
- Port 2: f_gnt = f_req & ~ldr_mode & ~hazard.
  - hazard = a port-1 write is granted this cycle and mem_addr1 == f_addr.
  - When f_gnt=1: mem_r_en2=1 and mem_addr2=f_addr; otherwise mem_r_en2=0.
- Read return: registers d_pend and f_pend are set on a read grant and cleared otherwise.
  - d_rvalid = d_pend, and d_rdata = mem_r_data1.
  - f_rvalid = f_pend, and f_rdata = mem_r_data2.
  - Data outputs are don't-care when the matching rvalid is 0.
- Writes produce no rvalid; the write-through value on mem_r_data1 is ignored.
- Back-to-back reads on every cycle are allowed; at most one read is outstanding per port (fixed 1-cycle latency).
- Address and data are passed through unmodified; there is no address-range checking.

## Timing
- Reset values: rr=0, d_pend=0, f_pend=0.
- Outputs during reset: all gnt, rvalid and mem strobes are 0; data and address outputs are don't-care.
- Grant latency is 0 cycles: a request is granted in the same cycle if it wins.
- Read latency: rvalid rises in the cycle after the grant edge.
- Throughput: one port-1 op plus one fetch per cycle.
- Simultaneous ldr+d every cycle: grants strictly alternate d, ldr, d, ldr... starting with d after reset.
- ldr_mode rising: fetch is blocked from that cycle on. A fetch granted in the previous cycle still completes (f_rvalid next cycle).
- Hazard stall lasts exactly as long as the same-address write is being granted; the fetch is granted in the first cycle without it.
- Reset asserted mid-read: pending rvalid is dropped immediately and never returned. After deassertion, the first grant is evaluated on the next edge.
- d_req with d_we toggling while ungranted is legal; the value sampled at the grant edge decides read vs write.

## Test plan
- Reset, then d read addr 0x0010 (mem holds 0xBEEF): d_gnt same cycle, mem_r_en1=1; next cycle d_rvalid=1, d_rdata=0xBEEF; rvalid low after.
- ldr and d write requests both held 4 cycles: grant order d, ldr, d, ldr; mem_w_en=1 each cycle, never with mem_r_en1.
- Fetch 0x0020 concurrent with d write to 0x0020 (0x1234): f_gnt=0 that cycle; granted next cycle, then f_rdata=0x1234. Fetch 0x0021 with the same write: granted immediately.
- ldr_mode=1 with f_req held: f_gnt stays 0 while ldr writes 0x0000..0x0003 proceed. Drop ldr_mode: f_gnt=1 the same cycle.
- Continuous fetch plus data reads for 8 cycles: 8 f_rvalid and 8 d_rvalid pulses with correct words, one cycle after each grant.
- Assert reset asynchronously between a d read grant and its return: d_rvalid goes 0 immediately. After release, the first contested port-1 grant goes to d (rr=0).
